// File: rtl/operand_pair_fifo_pkg.sv
// Package for operand_pair_fifo.
//   Holds the pairing FSM state type built on the shared state codes.
//   No ports.

package operand_pair_fifo_pkg;

`include "operand_pair_defs.vh"

    typedef enum logic [3:0] {
        ST_EXPECT_X = S_EXPECT_X,
        ST_HAVE_X   = S_HAVE_X
    } state_e;

endpackage

// File: rtl/operand_pair_defs.vh
// Shared definitions for the operand pair FIFO.
//   - FSM state codes for the pairing state machine.
//   - Entry width and field positions of one stored pair {x, y, odd}.
// Included inside operand_pair_fifo_pkg so the state codes are visible to
// every file that imports the package; the macros are global once defined.

`ifndef OPERAND_PAIR_DEFS_VH
`define OPERAND_PAIR_DEFS_VH

// One entry is {x[DATA_W-1:0], y[DATA_W-1:0], odd}.
`define OPF_ENTRY_W(dw) (2*(dw)+1)
`define OPF_ODD_BIT     0
`define OPF_Y_LSB       1
`define OPF_X_LSB(dw)   ((dw)+1)

`endif

localparam logic [3:0] S_EXPECT_X = 4'h0;
localparam logic [3:0] S_HAVE_X   = 4'h1;

// File: rtl/operand_pair_fifo_mem.sv
// Storage for operand pairs: entry array, read/write pointers and occupancy.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push_i           write wr_data_i at wr_ptr (caller guarantees not full)
//   pop_i            retire the entry at rd_ptr (caller guarantees not empty)
//   wr_data_i        entry to write
//   rd_data_o        entry at rd_ptr, combinational
//   count_o          current occupancy, 0 .. 2**AW

module operand_pair_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int AW     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [`OPF_ENTRY_W(DATA_W)-1:0]  wr_data_i,
    output logic [`OPF_ENTRY_W(DATA_W)-1:0]  rd_data_o,
    output logic [AW:0]                      count_o
);

    localparam int EW    = `OPF_ENTRY_W(DATA_W);
    localparam int DEPTH = 1 << AW;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is small and must read as zero after reset, so it
            // is reset explicitly; a large RAM would normally be left unreset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/operand_pair_fifo.sv
// Operand pair FIFO: pairs a scalar operand stream into (x, y) and buffers
// the pairs for the arithmetic stage. A trailing x flagged by in_last is
// padded with y = 0 and marked odd.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          input word handshake; in_ready depends only on
//                              the registered occupancy
//   in_data, in_last           operand word, end-of-stream flag
//   out_valid/out_ready        pair handshake at the FIFO head
//   out_x, out_y, out_odd      head pair fields
//   count                      FIFO occupancy
//   stall_cnt                  saturating count of cycles with in_valid while
//                              not ready; built only when the macro
//                              OPERAND_PAIR_FIFO_STALL_CNT_EN is defined,
//                              otherwise tied to zero

module operand_pair_fifo
    import operand_pair_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic              out_odd,
    output logic [AW:0]       count,
    output logic [15:0]       stall_cnt
);

    localparam int EW    = `OPF_ENTRY_W(DATA_W);
    localparam int DEPTH = 1 << AW;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic              in_accept;
    logic              push;
    logic              pop;
    logic [EW-1:0]     wr_entry;
    logic [EW-1:0]     rd_entry;

    // Ready comes from the registered count only, so a pop never opens the
    // input in the same cycle.
    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign in_accept = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        push     = 1'b0;
        wr_entry = '0;
        case (state_q)
            ST_EXPECT_X: begin
                if (in_accept) begin
                    if (in_last) begin
                        push     = 1'b1;
                        wr_entry = {in_data, {DATA_W{1'b0}}, 1'b1};
                    end else begin
                        x_d     = in_data;
                        state_d = ST_HAVE_X;
                    end
                end
            end
            ST_HAVE_X: begin
                if (in_accept) begin
                    push     = 1'b1;
                    wr_entry = {x_q, in_data, 1'b0};
                    state_d  = ST_EXPECT_X;
                end
            end
            default: state_d = ST_EXPECT_X;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EXPECT_X;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
        end
    end

    operand_pair_fifo_mem #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .count_o   (count)
    );

    assign out_x   = rd_entry[`OPF_X_LSB(DATA_W) +: DATA_W];
    assign out_y   = rd_entry[`OPF_Y_LSB +: DATA_W];
    assign out_odd = rd_entry[`OPF_ODD_BIT];

`ifdef OPERAND_PAIR_FIFO_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_operand_pair_fifo.sv
// Testbench for operand_pair_fifo: directed stimulus, expected pairs pushed
// into a scoreboard queue as words are accepted, a monitor compares the FIFO
// head against the queue on every falling edge and retires entries on pops.

module tb_operand_pair_fifo;

    localparam int DATA_W = 8;
    localparam int AW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;
    logic              out_odd;
    logic [AW:0]       count;
    logic [15:0]       stall_cnt;

    operand_pair_fifo #(.DATA_W(DATA_W), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_odd   (out_odd),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       odd;
    } pair_t;

    pair_t      exp_q[$];
    logic       have_x;
    logic [7:0] held_x;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         pops_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pairing model, updated when a word is accepted.
    task automatic model_accept(input logic [7:0] d, input logic last);
        pair_t p;
        if (!have_x) begin
            if (last) begin
                p = '{x: d, y: 8'h00, odd: 1'b1};
                exp_q.push_back(p);
            end else begin
                have_x = 1'b1;
                held_x = d;
            end
        end else begin
            p = '{x: held_x, y: d, odd: 1'b0};
            exp_q.push_back(p);
            have_x = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        else           model_accept(d, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (count != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, 32'(count), 32'd0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    // Monitor: head must match the scoreboard front whenever valid.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 32'(out_valid), 32'd0);
                end else begin
                    check("pair_head", 32'({out_x, out_y, out_odd}), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops_seen++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_before;
        logic [15:0] exp_stall;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        have_x    = 1'b0;
        held_x    = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x",     32'(out_x),     32'd0);
        check("rst_out_y",     32'(out_y),     32'd0);
        check("rst_out_odd",   32'(out_odd),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic pairing and one-cycle latency.
        out_ready = 1'b1;
        send(8'h03, 1'b0);
        check("basic_no_pair_yet", 32'(out_valid), 32'd0);
        send(8'h05, 1'b0);
        check("basic_valid_n1", 32'(out_valid), 32'd1);
        check("basic_count_1",  32'(count),     32'd1);
        @(posedge clk);
        #1;
        check("basic_count_0",  32'(count),     32'd0);
        check("basic_sb_empty", 32'(exp_q.size()), 32'd0);

        // Odd tail.
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b1);
        drain("odd");
        check("odd_state_expect_x", 32'(dut.state_q), 32'h0);

        // Fill to full, back-pressure, stall counter.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
        check("full_count",    32'(count),     32'd4);
        check("full_in_ready", 32'(in_ready),  32'd0);
        check("full_valid",    32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h18;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef OPERAND_PAIR_FIFO_STALL_CNT_EN
        exp_stall = 16'd5;
`else
        exp_stall = 16'd0;
`endif
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        check("full_held_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_same_cycle_as_pop", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_pop", 32'(in_ready), 32'd1);
        check("count_after_pop",    32'(count),    32'd3);
        send(8'h18, 1'b0);
        send(8'h19, 1'b0);
        check("refill_count", 32'(count), 32'd4);
        drain("full");

        // Simultaneous push and pop at count 2.
        send(8'h20, 1'b0);
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b0);
        check("simul_pre_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        send(8'h25, 1'b0);
        check("simul_count_stays_2", 32'(count), 32'd2);
        drain("simul");

        // Pointer wrap across 12 pairs with intermittent back-pressure.
        pops_before = pops_seen;
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 3 != 0);
            send(8'h40 + 8'(i), 1'b0);
        end
        drain("wrap");
        check("wrap_pairs_popped", 32'(pops_seen - pops_before), 32'd12);

        // Reset mid-operation with a held x and three buffered pairs.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 1'b0);
        send(8'h66, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_state", 32'(dut.state_q), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count",     32'(count),     32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        exp_q.delete();
        have_x = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h70, 1'b0);
        check("post_rst_no_pair", 32'(out_valid), 32'd0);
        send(8'h71, 1'b0);
        check("post_rst_pair_valid", 32'(out_valid), 32'd1);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_pair_fifo.md
Name: operand_pair_fifo

Overview:
Upstream feeder for the team's arithmetic stage, which consumes operand pairs (x, y). It accepts a single scalar operand stream, pairs consecutive words as x then y, and buffers the pairs in a small FIFO. It presents the pairs downstream with a valid/ready handshake. A trailing unpaired x, flagged by in_last, is padded with y = 0 and marked odd.

Parameters:
DATA_W, 8, operand width in bits.
AW, 2, FIFO address width; depth = 2**AW entries (default 4).

Ports:
clk  input  1  sole clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  an operand word is presented.
in_ready  output  1  the stage accepts the word this cycle.
in_data  input  DATA_W  operand word.
in_last  input  1  the word is the final one of the stream.
out_valid  output  1  the FIFO head holds a pair.
out_ready  input  1  downstream consumes the head.
out_x  output  DATA_W  first operand of the head pair.
out_y  output  DATA_W  second operand of the head pair; 0 when padded.
out_odd  output  1  the head pair was padded.
count  output  AW+1  current FIFO occupancy.
stall_cnt  output  16  input-stall counter (see Optional Feature).

Behaviour:
- Reset (clk, asynchronous active-high rst): state = S_EXPECT_X; x holding register = 0; read and write pointers = 0; count = 0; all storage entries = 0.
- Output values after reset: out_valid = 0; out_x = out_y = 0; out_odd = 0; in_ready = 1; stall_cnt = 0.
- Accept condition: in_accept = in_valid & in_ready. Pop condition: pop = out_valid & out_ready.
- in_ready = (count != 2**AW), decoded from registered count only. There is no combinational path from out_ready to in_ready.
- FSM state codes are 4'h0 (S_EXPECT_X) and 4'h1 (S_HAVE_X).
- S_EXPECT_X, accept with in_last = 0: capture in_data into the x holding register; go to S_HAVE_X.
- S_EXPECT_X, accept with in_last = 1: push {x = in_data, y = 0, odd = 1}; stay in S_EXPECT_X.
- S_HAVE_X, accept: push {held x, y = in_data, odd = 0}; go to S_EXPECT_X. in_last has no further effect here.
- Storage and pointers: write at wr_ptr, read at rd_ptr. Both pointers are AW bits and wrap modulo 2**AW.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- out_valid = (count != 0). out_x, out_y and out_odd are read combinationally from the entry at rd_ptr.
- Latency: pair-completing word accepted in cycle N -> out_valid = 1 in cycle N+1. There is no bypass path.
- Full: in_ready = 0 in both states. A pop in the same cycle does not enable a push that cycle; in_ready rises the cycle after the pop.
- Empty: out_valid = 0; out_ready is ignored; pointers do not move.
- Output stability: while out_valid = 1 and out_ready = 0, out_x, out_y and out_odd hold their values.
- Reset mid-operation: a held x and all buffered pairs are discarded; behaviour is identical to power-on reset.

Optional Feature:
Macro OPERAND_PAIR_FIFO_STALL_CNT_EN.
- Defined: stall_cnt is a 16-bit register, reset to 0. It increments each cycle with in_valid = 1 and in_ready = 0, and saturates at 16'hFFFF.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is built. The port list is identical in both builds.

Decomposition:
- Shared include file operand_pair_defs.vh holds:
  - FSM state localparams S_EXPECT_X = 4'h0, S_HAVE_X = 4'h1.
  - Entry-width macro: 2*DATA_W + 1.
  - Entry field bit-position constants.
- Sub-module operand_pair_fifo_mem holds the storage array, pointers and count, with a push/pop interface.
- Top level keeps the pairing FSM, the x holding register, the handshake logic and the stall counter.

Test Plan:
- Basic pairing: inputs 8'h03, then 8'h05, with out_ready = 1 -> one cycle later out_valid = 1, out_x = 03, out_y = 05, out_odd = 0; count returns 1 -> 0 after the pop.
- Odd tail: inputs 8'h0A (in_last = 0), 8'h0B, then 8'h0C (in_last = 1) -> pairs (0A, 0B, odd = 0) then (0C, 00, odd = 1); FSM ends in S_EXPECT_X.
- Full and back-pressure: out_ready = 0, drive 10 words -> count = 4 and in_ready = 0 after the 8th word. Assert out_ready for 1 cycle -> pair (w0, w1) is popped; in_ready = 1 the next cycle, not the same cycle.
- Simultaneous push and pop at count = 2 -> count stays 2; pairs emerge in order; pointer wrap verified across 12 pairs with no loss.
- Reset mid-operation: assert rst while in S_HAVE_X with count = 3 -> immediately out_valid = 0 and count = 0; the next two words form a fresh pair.
- Stall counter, macro defined: hold in_valid = 1 for 5 cycles while full -> stall_cnt = 5. Macro undefined: stall_cnt stays 0.
